// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time; illegal control codes bypass the ALU.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             grant_valid;
    logic             grant_port;
    logic             accept;
    logic [3:0]       sel_ctrl;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_legal;
    logic             rsp_taken;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0010, 4'b0011, 4'b0100,
            4'b1100, 4'b0110, 4'b0111, 4'b0001: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // The favoured port wins a tie; otherwise whichever port is valid.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = ptr;
        if (!ptr) begin
            if (req0_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end
        end else begin
            if (req1_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b0;
            end
        end
    end

    // Nothing is accepted while reset is held, even though state reads IDLE.
    assign accept     = reset_n && (state == IDLE) && grant_valid;
    assign req0_ready = accept && !grant_port;
    assign req1_ready = accept && grant_port;

    assign sel_ctrl   = grant_port ? req1_ctrl : req0_ctrl;
    assign sel_a      = grant_port ? req1_a    : req0_a;
    assign sel_b      = grant_port ? req1_b    : req0_b;
    assign sel_legal  = is_legal(sel_ctrl);

    assign alu_ctrl   = (state == ISSUE) ? ctrl_q : 4'b0000;
    assign alu_a      = (state == ISSUE) ? a_q    : '0;
    assign alu_b      = (state == ISSUE) ? b_q    : '0;

    assign rsp0_valid = (state == RESP) && !grant_id;
    assign rsp1_valid = (state == RESP) && grant_id;
    assign rsp_taken  = grant_id ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
            ctrl_q   <= 4'b0000;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_q   <= sel_ctrl;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        grant_id <= grant_port;
                        ptr      <= ~grant_port;
                        if (sel_legal) begin
                            state <= ISSUE;
                        end else begin
                            rsp_data <= '0;
                            rsp_zero <= 1'b0;
                            rsp_err  <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    rsp_data <= alu_result;
                    rsp_zero <= alu_zero;
                    rsp_err  <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_zero;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero, rsp_err, grant_id;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    function automatic logic legal(input logic [3:0] c);
        return (c == 4'b0000) || (c == 4'b0010) || (c == 4'b0011) || (c == 4'b0100) ||
               (c == 4'b1100) || (c == 4'b0110) || (c == 4'b0111) || (c == 4'b0001);
    endfunction

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return a + b;
            4'b1100: return a - b;
            4'b0110: return a << b[3:0];
            4'b0111: return WIDTH'($signed(a) >>> b[3:0]);
            4'b0001: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            default: return '0;
        endcase
    endfunction

    // Behavioural ALU the DUT drives.
    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int          model_ptr;
    int          winner;
    logic        v0, v1;
    logic [3:0]  c_w;
    logic [WIDTH-1:0] a_w, b_w, exp_data;
    logic        exp_zero, exp_err;
    int          bp;
    logic [3:0]  legal_codes [8];

    initial begin
        legal_codes = '{4'b0000, 4'b0010, 4'b0011, 4'b0100,
                        4'b1100, 4'b0110, 4'b0111, 4'b0001};
        reset_n    = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'b0100; req0_a = 16'h0005; req0_b = 16'h0003;
        req1_valid = 1'b1; req1_ctrl = 4'b0100; req1_a = 16'h0001; req1_b = 16'h0001;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset held with both requesters valid
        tick(); tick(); settle();
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
        chk("rst_alu_ctrl",   32'(alu_ctrl), 0);
        chk("rst_rsp_data",   32'(rsp_data), 0);
        chk("rst_grant_id",   32'(grant_id), 0);
        reset_n = 1'b1;
        settle();
        chk("rel_req0_ready", 32'(req0_ready), 1);
        chk("rel_req1_ready", 32'(req1_ready), 0);

        // Single ADD on port 0
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b0;
        settle();
        chk("add_alu_ctrl", 32'(alu_ctrl), 32'h4);
        chk("add_alu_a",    32'(alu_a), 5);
        chk("add_alu_b",    32'(alu_b), 3);
        chk("add_rsp0_early", 32'(rsp0_valid), 0);
        tick();
        chk("add_rsp0_valid", 32'(rsp0_valid), 1);
        chk("add_rsp1_valid", 32'(rsp1_valid), 0);
        chk("add_data", 32'(rsp_data), 8);
        chk("add_zero", 32'(rsp_zero), 0);
        chk("add_err",  32'(rsp_err), 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // SUB to zero on port 1 with backpressure; port 0 ready must be ignored
        req1_valid = 1'b1; req1_ctrl = 4'b1100; req1_a = 16'h1234; req1_b = 16'h1234;
        settle();
        chk("sub_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        tick();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("sub_rsp1_valid", 32'(rsp1_valid), 1);
            chk("sub_rsp0_valid", 32'(rsp0_valid), 0);
            chk("sub_data", 32'(rsp_data), 0);
            chk("sub_zero", 32'(rsp_zero), 1);
            chk("sub_grant", 32'(grant_id), 1);
            tick();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("sub_done_valid", 32'(rsp1_valid), 0);

        // Round-robin with both ports continuously valid
        req0_valid = 1'b1; req0_ctrl = 4'b0100; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_ctrl = 4'b0100; req1_a = 16'h0010; req1_b = 16'h0020;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("rr_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_grant_id", 32'(grant_id), i % 2);
            chk("rr_busy_ready", 32'({req0_ready, req1_ready}), 0);
            tick();
            chk("rr_rsp0_valid", 32'(rsp0_valid), (i % 2 == 0) ? 1 : 0);
            chk("rr_rsp1_valid", 32'(rsp1_valid), (i % 2 == 1) ? 1 : 0);
            chk("rr_data", 32'(rsp_data), (i % 2 == 0) ? 32'h3 : 32'h30);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Illegal code on port 0 never reaches the ALU
        req0_valid = 1'b1; req0_ctrl = 4'b1111; req0_a = 16'hAAAA; req0_b = 16'h5555;
        settle();
        chk("ill_req0_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("ill_alu_ctrl",   32'(alu_ctrl), 0);
        chk("ill_rsp0_valid", 32'(rsp0_valid), 1);
        chk("ill_err",  32'(rsp_err), 1);
        chk("ill_data", 32'(rsp_data), 0);
        chk("ill_zero", 32'(rsp_zero), 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Reset during ISSUE discards the transaction and clears the pointer
        req1_valid = 1'b1; req1_ctrl = 4'b0100; req1_a = 16'h0007; req1_b = 16'h0001;
        settle();
        chk("mid_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        chk("mid_in_issue", 32'(alu_ctrl), 32'h4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk("mid_ptr_req0", 32'(req0_ready), 1);
        chk("mid_ptr_req1", 32'(req1_ready), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_ptr = 0;

        // Randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            req0_ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 7)];
            req1_ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 7)];
            req0_a = 16'($urandom); req0_b = ($urandom_range(0, 4) == 0) ? req0_a : 16'($urandom);
            req1_a = 16'($urandom); req1_b = ($urandom_range(0, 4) == 0) ? req1_a : 16'($urandom);
            req0_valid = v0; req1_valid = v1;
            settle();
            winner = (v0 && v1) ? model_ptr : (v0 ? 0 : 1);
            c_w = winner ? req1_ctrl : req0_ctrl;
            a_w = winner ? req1_a : req0_a;
            b_w = winner ? req1_b : req0_b;
            exp_err  = !legal(c_w);
            exp_data = exp_err ? '0 : alu_fn(c_w, a_w, b_w);
            exp_zero = !exp_err && (exp_data == '0);
            chk("rnd_req0_ready", 32'(req0_ready), (winner == 0) ? 1 : 0);
            chk("rnd_req1_ready", 32'(req1_ready), (winner == 1) ? 1 : 0);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (!exp_err) begin
                settle();
                chk("rnd_alu_ctrl", 32'(alu_ctrl), 32'(c_w));
                chk("rnd_alu_a",    32'(alu_a), 32'(a_w));
                chk("rnd_alu_b",    32'(alu_b), 32'(b_w));
                chk("rnd_rsp_early", 32'({rsp0_valid, rsp1_valid}), 0);
                tick();
            end else begin
                chk("rnd_ill_alu", 32'(alu_ctrl), 0);
            end
            bp = $urandom_range(0, 3);
            for (int k = 0; k <= bp; k++) begin
                rsp0_ready = (k == bp) ? (winner == 0) : (winner == 1) && $urandom_range(0, 1) == 1;
                rsp1_ready = (k == bp) ? (winner == 1) : (winner == 0) && $urandom_range(0, 1) == 1;
                settle();
                chk("rnd_rsp_valid", 32'({rsp1_valid, rsp0_valid}), (winner == 1) ? 32'h2 : 32'h1);
                chk("rnd_grant", 32'(grant_id), 32'(winner));
                chk("rnd_data", 32'(rsp_data), 32'(exp_data));
                chk("rnd_zero", 32'(rsp_zero), 32'(exp_zero));
                chk("rnd_err",  32'(rsp_err),  32'(exp_err));
                tick();
            end
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            chk("rnd_done", 32'({rsp0_valid, rsp1_valid}), 0);
            model_ptr = 1 - winner;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single combinational ALU between two requesters (port 0: main datapath sequencer; port 1: auxiliary/debug unit). It accepts one operation at a time over a valid/ready handshake and drives the ALU control code and operands for one cycle. It registers the result and zero flag, then returns them to the winning requester over a second valid/ready handshake. Illegal control codes are rejected with an error flag and never reach the ALU.

## Interface
- WIDTH, 16, operand/result width in bits
- Clock  in  1  rising-edge clock
- ResetN  in  1  synchronous, active-low reset
- Req0Valid / Req1Valid  in  1  request present
- Req0Ready / Req1Ready  out  1  request accepted this cycle when high with Valid
- Req0Ctrl / Req1Ctrl  in  4  ALU control code
- Req0A, Req0B / Req1A, Req1B  in  WIDTH  operands
- AluCtrl  out  4  control code to ALU
- AluA, AluB  out  WIDTH  operands to ALU
- AluResult  in  WIDTH  ALU result (combinational from AluCtrl/AluA/AluB)
- AluZero  in  1  ALU zero flag
- Rsp0Valid / Rsp1Valid  out  1  response for port 0 / 1
- Rsp0Ready / Rsp1Ready  in  1  requester takes response
- RspData  out  WIDTH  registered result (shared by both ports)
- RspZero  out  1  registered zero flag
- RspErr  out  1  illegal control code flag
- GrantId  out  1  port owning the current/last transaction

## Operation
- FSM states: IDLE, ISSUE, RESP.
- Legal codes: 0000 AND, 0010 OR, 0011 XOR, 0100 ADD, 1100 SUB, 0110 SLL, 0111 SRA, 0001 SLT. All others are illegal.
- Priority pointer Ptr (1 bit) names the favoured port. Reset value is 0.
- IDLE behaviour:
  - Grant goes to Ptr's port if it is valid, else to the other port if it is valid.
  - ReqNReady = (state==IDLE) & grant-to-N. The signal is combinational, and at most one Ready is high.
  - On handshake: latch Ctrl/A/B into internal registers, set GrantId=N, set Ptr=~N.
  - Legal code: go to ISSUE. Illegal code: go directly to RESP with RspData=0, RspZero=0, RspErr=1.
- ISSUE behaviour:
  - AluCtrl/AluA/AluB are driven from the latched registers.
  - At the clock edge, capture RspData=AluResult, RspZero=AluZero, RspErr=0, then go to RESP.
- RESP behaviour:
  - RspGrantIdValid=1, and the other Rsp valid is 0.
  - RspData/RspZero/RspErr are held stable while RspValid is high and Ready is low.
  - On Ready: go to IDLE.
- Outside ISSUE, AluCtrl=0000 and AluA=AluB=0.
- Ready on the non-granted Rsp port is ignored.
- ReqValid deasserting without a handshake is legal. Nothing is latched in that case.
- Reset values (ResetN low at an edge): state IDLE, Ptr=0, GrantId=0, all Req*Ready and Rsp*Valid 0, AluCtrl=0000, AluA=AluB=0, RspData=0, RspZero=0, RspErr=0, latched operands 0.
- Reset mid-operation (ISSUE or RESP) discards the transaction. No response is ever produced for it.

## Timing
- Legal op: handshake at edge T, ALU driven during cycle T+1, RspValid high from T+2.
- Illegal op: RspValid high from T+1.
- Response handshake at edge R returns to IDLE. The next request handshake is possible at edge R+1.
- Minimum spacing is 3 cycles per legal op and 2 per illegal op.
- Simultaneous Req0Valid and Req1Valid in IDLE: the port named by Ptr wins. The loser's Ready stays 0 and it keeps Valid asserted. The loser wins the next arbitration.
- A requester that keeps Valid asserted while its response is pending is not accepted until IDLE.
- Ptr only updates on an accepted request.
- The ALU is purely combinational within ISSUE, so AluResult must settle within one cycle.

## Test plan
- Reset: hold ResetN=0 for 2 cycles with both ReqValid high -> all Ready/Valid 0, AluCtrl=0000, RspData=0. Release -> port 0 granted first (Req0Ready=1).
- Single ADD: port 0 sends Ctrl=0100, A=0x0005, B=0x0003 -> AluCtrl=0100, AluA=5, AluB=3 at T+1. Rsp0Valid=1 at T+2 with RspData=0x0008, RspZero=0, RspErr=0.
- SUB zero plus backpressure: port 1 sends 1100, A=B=0x1234, and Rsp1Ready is held low 3 cycles -> RspData=0, RspZero=1 held stable. Rsp0Valid=0 throughout. IDLE after Ready.
- Round-robin: both ports hold Valid continuously, each with 0100 -> grants alternate 0,1,0,1 (GrantId), each response on the matching Rsp port, with a 3-cycle spacing when Ready is tied high.
- Illegal code: port 0 sends Ctrl=1111 -> AluCtrl stays 0000. Rsp0Valid at T+1 with RspErr=1, RspData=0.
- Reset mid-op: assert ResetN=0 during ISSUE -> no Rsp*Valid ever rises for that op. Ptr=0 after reset.
